// File: rtl/cache_mem_arbiter.sv
// Shares one memory read channel between icache and dcache (round-robin, one read
// in flight) and holds one dcache write in a buffer; reads to the buffered line wait.
module cache_mem_arbiter #(
    parameter int LINE_BYTES = 16,
    parameter int LINE_OFF   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ic_rd_req,
    input  logic [2:0]              ic_rd_type,
    input  logic [31:0]             ic_rd_addr,
    output logic                    ic_rd_rdy,
    output logic                    ic_ret_valid,
    output logic                    ic_ret_last,
    input  logic                    dc_rd_req,
    input  logic [2:0]              dc_rd_type,
    input  logic [31:0]             dc_rd_addr,
    output logic                    dc_rd_rdy,
    output logic                    dc_ret_valid,
    output logic                    dc_ret_last,
    output logic [31:0]             ret_data,
    input  logic                    dc_wr_req,
    input  logic [2:0]              dc_wr_type,
    input  logic [31:0]             dc_wr_addr,
    input  logic [3:0]              dc_wr_wstrb,
    input  logic [LINE_BYTES*8-1:0] dc_wr_data,
    output logic                    dc_wr_rdy,
    output logic                    mem_rd_req,
    output logic [2:0]              mem_rd_type,
    output logic [31:0]             mem_rd_addr,
    input  logic                    mem_rd_rdy,
    input  logic                    mem_ret_valid,
    input  logic                    mem_ret_last,
    input  logic [31:0]             mem_ret_data,
    output logic                    mem_wr_req,
    output logic [2:0]              mem_wr_type,
    output logic [31:0]             mem_wr_addr,
    output logic [3:0]              mem_wr_wstrb,
    output logic [LINE_BYTES*8-1:0] mem_wr_data,
    input  logic                    mem_wr_rdy
);
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    rd_state_t               r_state;
    logic                    r_owner;     // 0 = icache, 1 = dcache
    logic                    r_last_dc;   // last completed read belonged to dcache
    logic                    r_mem_rd_req;
    logic [2:0]              r_rd_type;
    logic [31:0]             r_rd_addr;

    logic                    r_wb_full;
    logic [2:0]              r_wb_type;
    logic [31:0]             r_wb_addr;
    logic [3:0]              r_wb_wstrb;
    logic [LINE_BYTES*8-1:0] r_wb_data;

    logic [1:0]  w_req;
    logic [1:0]  w_hazard;
    logic [1:0]  w_elig;
    logic [1:0]  w_grant;
    logic [1:0]  w_ret_valid;
    logic [1:0]  w_ret_last;
    logic [31:0] w_addr [2];
    logic [2:0]  w_type [2];
    logic        w_wr_capture;
    logic        w_wr_drain;
    logic        w_idle;
    logic        w_resp;

    assign w_req        = {dc_rd_req, ic_rd_req};
    assign w_addr[0]    = ic_rd_addr;
    assign w_addr[1]    = dc_rd_addr;
    assign w_type[0]    = ic_rd_type;
    assign w_type[1]    = dc_rd_type;
    assign w_wr_capture = dc_wr_req && !r_wb_full;
    assign w_wr_drain   = r_wb_full && mem_wr_rdy;
    assign w_idle       = (r_state == R_IDLE);
    assign w_resp       = (r_state == R_RESP);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // A write being captured this cycle blocks its line just like a buffered one.
            assign w_hazard[gi] =
                (r_wb_full && (w_addr[gi][31:LINE_OFF] == r_wb_addr[31:LINE_OFF])) ||
                (w_wr_capture && (w_addr[gi][31:LINE_OFF] == dc_wr_addr[31:LINE_OFF]));
            assign w_elig[gi]      = w_req[gi] && !w_hazard[gi];
            assign w_ret_valid[gi] = w_resp && (r_owner == 1'(gi)) && mem_ret_valid;
            assign w_ret_last[gi]  = w_resp && (r_owner == 1'(gi)) && mem_ret_last;
        end
    endgenerate

    assign w_grant[1] = w_idle && w_elig[1] && (!w_elig[0] || !r_last_dc);
    assign w_grant[0] = w_idle && w_elig[0] && !w_grant[1];

    assign ic_rd_rdy    = w_grant[0];
    assign dc_rd_rdy    = w_grant[1];
    assign ic_ret_valid = w_ret_valid[0];
    assign dc_ret_valid = w_ret_valid[1];
    assign ic_ret_last  = w_ret_last[0];
    assign dc_ret_last  = w_ret_last[1];
    assign ret_data     = w_resp ? mem_ret_data : 32'd0;

    assign mem_rd_req   = r_mem_rd_req;
    assign mem_rd_type  = r_rd_type;
    assign mem_rd_addr  = r_rd_addr;

    assign dc_wr_rdy    = !r_wb_full;
    assign mem_wr_req   = r_wb_full;
    assign mem_wr_type  = r_wb_type;
    assign mem_wr_addr  = r_wb_addr;
    assign mem_wr_wstrb = r_wb_wstrb;
    assign mem_wr_data  = r_wb_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= R_IDLE;
            r_owner      <= 1'b0;
            r_last_dc    <= 1'b0;
            r_mem_rd_req <= 1'b0;
            r_rd_type    <= 3'd0;
            r_rd_addr    <= 32'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (|w_grant) begin
                        r_state      <= R_REQ;
                        r_owner      <= w_grant[1];
                        r_mem_rd_req <= 1'b1;
                        r_rd_type    <= w_grant[1] ? w_type[1] : w_type[0];
                        r_rd_addr    <= w_grant[1] ? w_addr[1] : w_addr[0];
                    end
                end
                R_REQ: begin
                    if (mem_rd_rdy) begin
                        r_state      <= R_RESP;
                        r_mem_rd_req <= 1'b0;
                    end
                end
                R_RESP: begin
                    // Only the last flag ends a read; beat count is left to memory.
                    if (mem_ret_valid && mem_ret_last) begin
                        r_state   <= R_IDLE;
                        r_last_dc <= r_owner;
                    end
                end
                default: begin
                    r_state      <= R_IDLE;
                    r_mem_rd_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_full  <= 1'b0;
            r_wb_type  <= 3'd0;
            r_wb_addr  <= 32'd0;
            r_wb_wstrb <= 4'd0;
            r_wb_data  <= '0;
        end else if (w_wr_capture) begin
            r_wb_full  <= 1'b1;
            r_wb_type  <= dc_wr_type;
            r_wb_addr  <= dc_wr_addr;
            r_wb_wstrb <= dc_wr_wstrb;
            r_wb_data  <= dc_wr_data;
        end else if (w_wr_drain) begin
            r_wb_full  <= 1'b0;
        end
    end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one memory-side read/write request interface between the instruction cache (port 0, read-only) and the data cache (port 1, read/write).
- Reads: one outstanding transaction, round-robin arbitration, returned beats routed to the owning cache.
- Writes: dcache writes (cache-line writeback or uncached word) go into a one-entry write buffer that drains to memory. A read that hits the buffered line is held until the buffer drains.
- Sits between the two cache instances and the AXI bridge.

Parameters:
- LINE_BYTES, 16, cache line size in bytes; wr_data width is LINE_BYTES*8.
- LINE_OFF, 4, log2(LINE_BYTES); address bits compared for hazards are [31:LINE_OFF].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ic_rd_req  in  1  icache read request
- ic_rd_type  in  3  000 byte, 001 half, 010 word, 100 line
- ic_rd_addr  in  32  icache read address
- ic_rd_rdy  out  1  icache read accepted this cycle
- ic_ret_valid  out  1  beat valid to icache
- ic_ret_last  out  1  last beat to icache
- dc_rd_req / dc_rd_type / dc_rd_addr / dc_rd_rdy / dc_ret_valid / dc_ret_last  same as icache, for dcache
- ret_data  out  32  returned beat data, shared by both caches
- dc_wr_req  in  1  dcache write; only asserted while dc_wr_rdy=1
- dc_wr_type  in  3  010 word, 100 line
- dc_wr_addr  in  32  write address
- dc_wr_wstrb  in  4  byte strobes (word writes)
- dc_wr_data  in  LINE_BYTES*8  write data
- dc_wr_rdy  out  1  write buffer empty
- mem_rd_req  out  1  read request to memory
- mem_rd_type  out  3  type of the granted read
- mem_rd_addr  out  32  address of the granted read
- mem_rd_rdy  in  1  memory accepts read
- mem_ret_valid  in  1  memory beat valid
- mem_ret_last  in  1  memory last beat
- mem_ret_data  in  32  memory beat data
- mem_wr_req  out  1  buffered write valid
- mem_wr_type  out  3  buffered write type
- mem_wr_addr  out  32  buffered write address
- mem_wr_wstrb  out  4  buffered write strobes
- mem_wr_data  out  LINE_BYTES*8  buffered write data
- mem_wr_rdy  in  1  memory accepts write

Behaviour:
- Reset (synchronous, active-high) on the clk edge:
  - all outputs 0, read FSM to R_IDLE, write buffer empty, RR pointer favours dcache.
  - Any in-flight read or buffered write is discarded.
  - dc_wr_rdy is 1 from the first cycle after reset.
- Read FSM states R_IDLE, R_REQ, R_RESP (one-hot or binary).
- R_IDLE:
  - Eligible requester = rd_req=1 and no hazard.
  - Hazard = buffer full and rd_addr[31:LINE_OFF] == buffered addr[31:LINE_OFF], or dc_wr_req capturing the same line this cycle.
  - Both eligible: grant the one not granted last; otherwise grant the single eligible one.
  - Winner's rd_rdy=1 combinationally in this cycle; type/addr/owner latched; go to R_REQ.
  - Loser's rd_rdy=0.
- R_REQ: mem_rd_req=1 with latched type/addr. On mem_rd_rdy=1, go to R_RESP; mem_rd_req drops next cycle.
- R_RESP:
  - Beats pass through combinationally: owner's ret_valid=mem_ret_valid, ret_last=mem_ret_last, ret_data=mem_ret_data; the other port's ret_valid=0.
  - On mem_ret_valid&&mem_ret_last, update the RR pointer and return to R_IDLE.
  - A new grant is allowed the next cycle, never in the same cycle.
- Word read (type 010): exactly one beat, which has last=1.
- Line read: LINE_BYTES/4 beats. Beat count is not checked; termination is by last only.
- mem_ret_valid outside R_RESP is ignored.
- Write buffer:
  - Empty: dc_wr_rdy=1. dc_wr_req=1 captures type/addr/wstrb/data; buffer becomes full next cycle.
  - Full: dc_wr_rdy=0, mem_wr_req=1 holding captured fields stable. On mem_wr_rdy=1, buffer becomes empty next cycle.
  - Capture and drain can never occur in the same cycle.
  - Write draining runs independently of the read FSM; a read and a write may both be outstanding.
- Hazard only delays the grant. The blocked read keeps rd_rdy=0 and wins once the buffer drains, subject to RR.
- Hazard compare is on line address even for word accesses, which is conservative.

Test Plan:
- Only ic_rd_req, line 0x1C000040; mem_rd_rdy after 2 cycles; 4 beats 0xA0..0xA3 -> ic_rd_rdy one cycle; mem_rd_addr=0x1C000040, type=100; ic_ret_valid on 4 beats with last on 0xA3; dc_ret_valid stays 0.
- ic and dc request in the same R_IDLE cycle, repeated 4 times -> grants alternate dc, ic, dc, ic; the non-granted rd_rdy stays 0.
- dc writes line 0x00001230 with mem_wr_rdy=0, then dc reads 0x00001234 -> no dc_rd_rdy and no mem_rd_req until mem_wr_rdy pulses. Grant follows the cycle after the buffer empties.
- Buffered write to line 0x2000, ic reads 0x3000 -> read granted immediately while mem_wr_req stays 1.
- Uncached dc word read 0xBFAF8000, type 010 -> single beat with ret_last=1; FSM back in R_IDLE the next cycle.
- Assert reset during R_RESP with buffer full -> next cycle all outputs 0, dc_wr_rdy=1, FSM in R_IDLE; a later ic request is granted normally.
